// File: rtl/hms_countdown_timer_if.sv
// Command/status bundle for the HH:MM:SS countdown timer.
// The master side issues commands and presets; the slave side returns the count and status.
interface hms_countdown_timer_if;
    logic       tick;
    logic       load;
    logic [7:0] load_h;
    logic [7:0] load_m;
    logic [7:0] load_s;
    logic       start;
    logic       stop;
    logic [7:0] hours;
    logic [7:0] mins;
    logic [7:0] secs;
    logic       running;
    logic       done;

    modport master (
        output tick, load, load_h, load_m, load_s, start, stop,
        input  hours, mins, secs, running, done
    );

    modport slave (
        input  tick, load, load_h, load_m, load_s, start, stop,
        output hours, mins, secs, running, done
    );
endinterface

// File: rtl/hms_countdown_timer.sv
// HH:MM:SS down-counter: loads a preset, decrements once per 1 Hz tick through a
// sec -> min -> hour borrow chain, stops at 00:00:00 and pulses done for one cycle.
module hms_countdown_timer #(
    parameter int unsigned HOUR_MAX = 23,
    parameter int unsigned MS_MAX   = 59
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    hms_countdown_timer_if.slave  io_bus
);
    localparam logic [7:0] HOUR_MAX_V = 8'(HOUR_MAX);
    localparam logic [7:0] MS_MAX_V   = 8'(MS_MAX);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    logic [1:0] r_state;
    logic [7:0] r_hours;
    logic [7:0] r_mins;
    logic [7:0] r_secs;
    logic       r_running;
    logic       r_done;

    logic [1:0] w_state_nxt;
    logic [7:0] w_hours_nxt;
    logic [7:0] w_mins_nxt;
    logic [7:0] w_secs_nxt;
    logic       w_done_nxt;

    logic [7:0] w_dec_h;
    logic [7:0] w_dec_m;
    logic [7:0] w_dec_s;
    logic       w_is_zero;
    logic       w_is_last;

    function automatic logic [7:0] f_sat(input logic [7:0] val, input logic [7:0] lim);
        return (val > lim) ? lim : val;
    endfunction

    assign w_is_zero = (r_hours == 8'd0) && (r_mins == 8'd0) && (r_secs == 8'd0);
    assign w_is_last = (r_hours == 8'd0) && (r_mins == 8'd0) && (r_secs == 8'd1);

    // Borrow chain: one second less than the current time, saturating at zero.
    always_comb begin
        w_dec_h = r_hours;
        w_dec_m = r_mins;
        w_dec_s = r_secs;
        if (r_secs != 8'd0) begin
            w_dec_s = r_secs - 8'd1;
        end else if (r_mins != 8'd0) begin
            w_dec_s = MS_MAX_V;
            w_dec_m = r_mins - 8'd1;
        end else if (r_hours != 8'd0) begin
            w_dec_s = MS_MAX_V;
            w_dec_m = MS_MAX_V;
            w_dec_h = r_hours - 8'd1;
        end
    end

    // Command decode, highest priority first: load > stop > start > tick.
    always_comb begin
        w_state_nxt = r_state;
        w_hours_nxt = r_hours;
        w_mins_nxt  = r_mins;
        w_secs_nxt  = r_secs;
        w_done_nxt  = 1'b0;

        if (io_bus.load) begin
            w_hours_nxt = f_sat(io_bus.load_h, HOUR_MAX_V);
            w_mins_nxt  = f_sat(io_bus.load_m, MS_MAX_V);
            w_secs_nxt  = f_sat(io_bus.load_s, MS_MAX_V);
            w_state_nxt = ST_IDLE;
        end else if (io_bus.stop) begin
            if (r_state == ST_RUN) begin
                w_state_nxt = ST_PAUSED;
            end
        end else if (io_bus.start) begin
            if (((r_state == ST_IDLE) || (r_state == ST_PAUSED)) && !w_is_zero) begin
                w_state_nxt = ST_RUN;
            end
        end else if (io_bus.tick && (r_state == ST_RUN) && !w_is_zero) begin
            w_hours_nxt = w_dec_h;
            w_mins_nxt  = w_dec_m;
            w_secs_nxt  = w_dec_s;
            if (w_is_last) begin
                w_state_nxt = ST_EXPIRED;
                w_done_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= ST_IDLE;
            r_hours   <= 8'd0;
            r_mins    <= 8'd0;
            r_secs    <= 8'd0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hours   <= w_hours_nxt;
            r_mins    <= w_mins_nxt;
            r_secs    <= w_secs_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_done    <= w_done_nxt;
        end
    end

    assign io_bus.hours   = r_hours;
    assign io_bus.mins    = r_mins;
    assign io_bus.secs    = r_secs;
    assign io_bus.running = r_running;
    assign io_bus.done    = r_done;
endmodule

// File: tb/tb_hms_countdown_timer.sv
// Bench for hms_countdown_timer: directed vector table, then random commands checked
// against a total-seconds reference model.
module tb_hms_countdown_timer;
    logic clk = 1'b0;
    logic rst;

    hms_countdown_timer_if bus ();

    hms_countdown_timer #(
        .HOUR_MAX (23),
        .MS_MAX   (59)
    ) u_dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst_n;
        bit ld;
        int h;
        int m;
        int s;
        bit st;
        bit sp;
        bit tk;
        int eh;
        int em;
        int es;
        bit er;
        bit ed;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: time held as total seconds, state as a small int.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;
    int m_total;
    int m_state;
    bit m_done;

    function automatic void add(bit r, bit ld, int h, int m, int s, bit st, bit sp, bit tk,
                                int eh, int em, int es, bit er, bit ed);
        vec_t v;
        v.rst_n = r; v.ld = ld; v.h = h; v.m = m; v.s = s;
        v.st = st; v.sp = sp; v.tk = tk;
        v.eh = eh; v.em = em; v.es = es; v.er = er; v.ed = ed;
        vecs.push_back(v);
    endfunction

    task automatic drive(bit r, bit ld, int h, int m, int s, bit st, bit sp, bit tk);
        rst         = r;
        bus.load    = ld;
        bus.load_h  = 8'(h);
        bus.load_m  = 8'(m);
        bus.load_s  = 8'(s);
        bus.start   = st;
        bus.stop    = sp;
        bus.tick    = tk;
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, int eh, int em, int es, bit er, bit ed);
        check($sformatf("%s hours", tag), int'(bus.hours), eh);
        check($sformatf("%s mins", tag), int'(bus.mins), em);
        check($sformatf("%s secs", tag), int'(bus.secs), es);
        check($sformatf("%s running", tag), int'(bus.running), int'(er));
        check($sformatf("%s done", tag), int'(bus.done), int'(ed));
    endtask

    function automatic int clampi(int v, int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic void model_step(bit r, bit ld, int h, int m, int s,
                                       bit st, bit sp, bit tk);
        m_done = 1'b0;
        if (!r) begin
            m_total = 0;
            m_state = M_IDLE;
        end else if (ld) begin
            m_total = clampi(h, 23) * 3600 + clampi(m, 59) * 60 + clampi(s, 59);
            m_state = M_IDLE;
        end else if (sp) begin
            if (m_state == M_RUN) m_state = M_PAUSED;
        end else if (st) begin
            if ((m_state == M_IDLE || m_state == M_PAUSED) && m_total > 0) m_state = M_RUN;
        end else if (tk && m_state == M_RUN && m_total > 0) begin
            m_total--;
            if (m_total == 0) begin
                m_state = M_EXPIRED;
                m_done  = 1'b1;
            end
        end
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset, then reset overriding load+start+tick mid-count.
        add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1,   0, 59, 59, 1, 0);
        add(0, 1, 5, 5, 5, 1, 0, 1,   0, 0, 0, 0, 0);
        // 00:00:03 countdown with spaced ticks and expiry.
        add(1, 1, 0, 0, 3, 0, 0, 0,   0, 0, 3, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0,   0, 0, 3, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 2, 1, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);
        // Clamp on load.
        add(1, 1, 30, 75, 99, 0, 0, 0,   23, 59, 59, 0, 0);
        add(1, 1, 255, 60, 200, 0, 0, 0,   23, 59, 59, 0, 0);
        // Pause / resume.
        add(1, 1, 0, 0, 10, 0, 0, 0,   0, 0, 10, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0,   0, 0, 10, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 9, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 8, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 1,   0, 0, 8, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 8, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0,   0, 0, 8, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 7, 1, 0);
        // Load beats start and tick while running.
        add(1, 1, 0, 5, 0, 0, 0, 0,   0, 5, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0,   0, 5, 0, 1, 0);
        add(1, 1, 0, 0, 2, 1, 0, 1,   0, 0, 2, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0,   0, 0, 2, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);
        // start+stop from PAUSED, start with zero time, stop in IDLE.
        add(1, 1, 0, 0, 4, 0, 0, 0,   0, 0, 4, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 4, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0,   0, 0, 4, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 4, 0, 0);
        add(1, 0, 0, 0, 0, 1, 1, 0,   0, 0, 4, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0,   0, 0, 4, 1, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].ld, vecs[i].h, vecs[i].m, vecs[i].s,
                  vecs[i].st, vecs[i].sp, vecs[i].tk);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].eh, vecs[i].em, vecs[i].es,
                      vecs[i].er, vecs[i].ed);
        end

        // Random phase: small presets so expiry is reached often.
        for (int c = 0; c < 3000; c++) begin
            bit r, ld, st, sp, tk;
            int h, m, s;
            r  = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
            ld = ($urandom_range(0, 24) == 0);
            h  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : 0;
            m  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 80) : $urandom_range(0, 1);
            s  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 19) == 0);
            tk = ($urandom_range(0, 1) == 0);
            drive(r, ld, h, m, s, st, sp, tk);
            @(posedge clk);
            model_step(r, ld, h, m, s, st, sp, tk);
            #1;
            check_all($sformatf("rnd%0d", c), m_total / 3600, (m_total / 60) % 60,
                      m_total % 60, (m_state == M_RUN), m_done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hms_countdown_timer.md
Name: hms_countdown_timer

Overview:
- Hours/minutes/seconds down-counter for the digital clock: the count-down counterpart of the mod-24 hour / mod-60 up-counter chain.
- Loads a preset time, decrements once per 1 Hz tick through a borrow chain (sec -> min -> hour), stops at 00:00:00 and pulses done.
- Sits beside the up-counter chain and shares its 1 Hz tick and binary 8-bit value format, so the same display path drives either.

Parameters:
- HOUR_MAX, 23, largest loadable hour value; loaded hours above it are clamped to it.
- MS_MAX, 59, largest loadable minute/second value and the borrow reload value.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-low reset.
- tick  input  1  1 Hz enable, one clk cycle wide; decrement request.
- load  input  1  one-cycle command: capture load_h/load_m/load_s.
- load_h  input  8  preset hours, binary.
- load_m  input  8  preset minutes, binary.
- load_s  input  8  preset seconds, binary.
- start  input  1  one-cycle command: begin or resume counting.
- stop  input  1  one-cycle command: pause counting.
- hours  output  8  current hours, binary.
- mins  output  8  current minutes, binary.
- secs  output  8  current seconds, binary.
- running  output  1  high while state is RUN.
- done  output  1  one-cycle pulse on reaching 00:00:00.

Behaviour:
- Reset (rst==0 at a clk edge): hours=mins=secs=0, state=IDLE, running=0, done=0. Reset overrides every other input, including mid-count.
- FSM states: IDLE, RUN, PAUSED, EXPIRED.
- Command priority, highest first: reset > load > stop > start > tick.
- load (any state):
  - Registers the preset next edge; state becomes IDLE.
  - Each field saturates: load_h>HOUR_MAX -> HOUR_MAX; load_m or load_s>MS_MAX -> MS_MAX.
  - Any start, stop or tick in the same cycle is ignored.
- start:
  - From IDLE or PAUSED with a nonzero time -> RUN next edge.
  - With time 00:00:00, or in RUN or EXPIRED: ignored.
  - A tick in the same cycle as start is not applied.
- stop: RUN -> PAUSED. A tick in the same cycle is not applied. Ignored in other states. stop and start together: stop wins.
- tick in RUN, one decrement per tick, result visible the edge after the tick:
  - secs>0: secs-1.
  - secs==0, mins>0: secs=MS_MAX, mins-1.
  - secs==0, mins==0, hours>0: secs=MS_MAX, mins=MS_MAX, hours-1.
- Expiry: when a tick takes the time from 00:00:01 to 00:00:00, on that same edge:
  - state -> EXPIRED, running=0;
  - done=1 for exactly one cycle.
- tick outside RUN: no effect.
- EXPIRED: holds 00:00:00 until load or reset; start is ignored. done never re-asserts without a new load+start.
- running is registered and equals (state==RUN). There is no combinational path from any input to any output.
- Latency: command/tick to output change = 1 clk.
- Outputs never leave the ranges 0..HOUR_MAX / 0..MS_MAX, and never underflow below zero.

Test Plan:
- Reset with clk running, then load 01:00:00 + start + 1 tick, then rst=0 -> next edge 00:00:00, running=0, done=0, state IDLE.
- Load 00:00:03, start, 3 ticks spaced 5 clks apart -> secs 2,1,0; done high exactly one cycle, on the edge of the third tick's update; running falls on that same edge; a 4th tick leaves 00:00:00.
- Load 01:00:00, start, 1 tick -> 00:59:59 (double borrow). Load 30:75:99 -> clamps to 23:59:59.
- Load 00:00:10, start, 2 ticks -> 00:00:08; stop together with a tick -> stays 00:00:08, PAUSED; 3 ticks -> unchanged; start -> RUN; 1 tick -> 00:00:07.
- In RUN at 00:05:00, assert load(00:00:02)+start+tick in one cycle -> 00:00:02, IDLE, running=0; start with zero time after expiry -> ignored, done stays 0.
- Start and stop in the same cycle from PAUSED -> remains PAUSED; start from IDLE with 00:00:00 loaded -> stays IDLE.
